// File: rtl/bus_responder_pkg.sv
// Shared constants and response-entry type for the bus responder and its response FIFO.
package bus_responder_pkg;

    localparam int unsigned ADDR_W        = 2;
    localparam int unsigned TAG_W         = 4;
    localparam int unsigned LATENCY_DEF   = 2;
    localparam int unsigned RSP_DEPTH     = 4;
    localparam int unsigned LOG_RSP_DEPTH = 2;
    localparam int unsigned PTR_W         = LOG_RSP_DEPTH;
    localparam int unsigned CNT_W         = LOG_RSP_DEPTH + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  data;
    } rsp_entry_t;

endpackage

// File: rtl/bus_responder_rsp_fifo.sv
// Circular response FIFO with separate occupancy count; head entry is always presented.
module bus_responder_rsp_fifo #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned RSPDEPTH    = 4,
    parameter int unsigned LOGRSPDEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [LOGRSPDEPTH:0]   count
);

    logic [WIDTH-1:0]         mem_q [RSPDEPTH];
    logic [LOGRSPDEPTH-1:0]   head_q, tail_q;
    logic [LOGRSPDEPTH:0]     count_q, count_d;
    logic                     do_push, do_pop, full;

    always_comb begin
        full       = (count_q == (LOGRSPDEPTH+1)'(RSPDEPTH));
        do_pop     = pop && (count_q != '0);
        do_push    = push && (!full || do_pop);
        head_valid = (count_q != '0);
        head_data  = mem_q[head_q];
        count      = count_q;
        count_d    = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(RSPDEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= push_data;
                tail_q <= (tail_q == LOGRSPDEPTH'(RSPDEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (do_pop) begin
                head_q <= (head_q == LOGRSPDEPTH'(RSPDEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Target-side request responder: writes stamp the sequence tag into a local store, reads
// return the stored tag through a fixed-latency pipeline into a credit-protected response FIFO.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int unsigned WIDTH       = ADDR_W,
    parameter int unsigned DWIDTH      = TAG_W,
    parameter int unsigned LATENCY     = LATENCY_DEF,
    parameter int unsigned RSPDEPTH    = RSP_DEPTH,
    parameter int unsigned LOGRSPDEPTH = LOG_RSP_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              validin,
    input  logic              isread,
    input  logic [WIDTH-1:0]  inaddr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_addr,
    output logic [DWIDTH-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] wrcount
);

    localparam int unsigned EW    = WIDTH + DWIDTH;
    localparam int unsigned CW    = LOGRSPDEPTH + 1;
    localparam int unsigned DEPTH = 2 ** WIDTH;

    logic [DWIDTH-1:0] store_q [DEPTH];
    logic [DWIDTH-1:0] wrcount_q;
    logic [LATENCY-1:0] pipe_valid_q;
    logic [EW-1:0]      pipe_entry_q [LATENCY];
    logic [CW-1:0]      inflight_q, inflight_d, fifo_count;
    logic [CW:0]        credit_used;
    logic               accept, accept_rd, accept_wr, push;
    logic [EW-1:0]      head_data;

    // Reads in flight hold a FIFO credit from acceptance, so the FIFO can never overflow.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
        req_ready   = !reset && (credit_used < (CW+1)'(RSPDEPTH));
        accept      = validin && req_ready;
        accept_rd   = accept && isread;
        accept_wr   = accept && !isread;
        push        = pipe_valid_q[LATENCY-1];
        inflight_d  = inflight_q + CW'(accept_rd) - CW'(push);
        wrcount     = wrcount_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                store_q[i] <= '0;
            end
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_entry_q[i] <= '0;
            end
            wrcount_q    <= '0;
            pipe_valid_q <= '0;
            inflight_q   <= '0;
        end else begin
            if (accept_wr) begin
                store_q[inaddr] <= wrcount_q;
                wrcount_q       <= wrcount_q + 1'b1;
            end
            pipe_valid_q[0] <= accept_rd;
            pipe_entry_q[0] <= {inaddr, store_q[inaddr]};
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_entry_q[i] <= pipe_entry_q[i-1];
            end
            inflight_q <= inflight_d;
        end
    end

    bus_responder_rsp_fifo #(
        .WIDTH       (EW),
        .RSPDEPTH    (RSPDEPTH),
        .LOGRSPDEPTH (LOGRSPDEPTH)
    ) u_rsp_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (pipe_entry_q[LATENCY-1]),
        .pop        (rsp_ready),
        .head_valid (rsp_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign {rsp_addr, rsp_data} = head_data;

endmodule

// File: tb/tb_bus_responder.sv
// Directed vector table plus hand-written sequences for back-pressure, wrap and reset cases.
module tb_bus_responder;
    import bus_responder_pkg::*;

    logic       clock = 1'b0;
    logic       reset, validin, isread, rsp_ready;
    logic [1:0] inaddr;
    logic       req_ready, rsp_valid;
    logic [1:0] rsp_addr;
    logic [3:0] rsp_data, wrcount;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       validin;
        logic       isread;
        logic [1:0] addr;
        logic       rsp_ready;
        logic       exp_req_ready;
        logic       exp_rsp_valid;
        rsp_entry_t exp_rsp;
        logic [3:0] exp_wrcount;
    } vec_t;

    vec_t vecs [12];

    bus_responder dut (
        .clock     (clock),
        .reset     (reset),
        .validin   (validin),
        .isread    (isread),
        .inaddr    (inaddr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .wrcount   (wrcount)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic v, logic rd, logic [1:0] a, logic rr, logic er,
                                logic ev, logic [1:0] ea, logic [3:0] ed, logic [3:0] ew);
        vec_t r;
        r.validin       = v;
        r.isread        = rd;
        r.addr          = a;
        r.rsp_ready     = rr;
        r.exp_req_ready = er;
        r.exp_rsp_valid = ev;
        r.exp_rsp.addr  = ea;
        r.exp_rsp.data  = ed;
        r.exp_wrcount   = ew;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic [1:0] a, input logic rr);
        validin   = v;
        isread    = rd;
        inaddr    = a;
        rsp_ready = rr;
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check({tag, "_req_ready_in_reset"}, 32'(req_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check({tag, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rst_rsp_addr"}, 32'(rsp_addr), 32'd0);
        check({tag, "_rst_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rst_wrcount"}, 32'(wrcount), 32'd0);
        check({tag, "_rst_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one read, wait (bounded) for its response, check latency and contents, pop it.
    task automatic read_and_check(input string tag, input logic [1:0] a, input logic [3:0] d);
        int n;
        drive(1'b1, 1'b1, a, 1'b1);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 8) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(n), 32'd2);
            check({tag, "_addr"}, 32'(rsp_addr), 32'(a));
            check({tag, "_data"}, 32'(rsp_data), 32'(d));
            tick();
        end
    endtask

    task automatic expect_head(input string tag, input logic [1:0] a, input logic [3:0] d);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_addr"}, 32'(rsp_addr), 32'(a));
        check({tag, "_data"}, 32'(rsp_data), 32'(d));
    endtask

    initial begin
        reset     = 1'b1;
        validin   = 1'b0;
        isread    = 1'b0;
        inaddr    = '0;
        rsp_ready = 1'b0;

        // Tests 1 and 2: write/write/read addr 1, read unwritten addr 3, write-then-read addr 2.
        vecs[0]  = mk(1, 0, 2'd1, 0, 1, 0, 2'd0, 4'd0, 4'd0);
        vecs[1]  = mk(1, 0, 2'd1, 0, 1, 0, 2'd0, 4'd0, 4'd1);
        vecs[2]  = mk(1, 1, 2'd1, 1, 1, 0, 2'd0, 4'd0, 4'd2);
        vecs[3]  = mk(0, 0, 2'd0, 1, 1, 0, 2'd0, 4'd0, 4'd2);
        vecs[4]  = mk(0, 0, 2'd0, 1, 1, 0, 2'd0, 4'd0, 4'd2);
        vecs[5]  = mk(0, 0, 2'd0, 1, 1, 1, 2'd1, 4'd1, 4'd2);
        vecs[6]  = mk(1, 1, 2'd3, 1, 1, 0, 2'd0, 4'd0, 4'd2);
        vecs[7]  = mk(1, 0, 2'd2, 1, 1, 0, 2'd0, 4'd0, 4'd2);
        vecs[8]  = mk(1, 1, 2'd2, 1, 1, 0, 2'd0, 4'd0, 4'd3);
        vecs[9]  = mk(0, 0, 2'd0, 1, 1, 1, 2'd3, 4'd0, 4'd3);
        vecs[10] = mk(0, 0, 2'd0, 1, 1, 0, 2'd0, 4'd0, 4'd3);
        vecs[11] = mk(0, 0, 2'd0, 1, 1, 1, 2'd2, 4'd2, 4'd3);

        do_reset("r0");
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].validin, vecs[i].isread, vecs[i].addr, vecs[i].rsp_ready);
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_req_ready));
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp_valid));
            if (vecs[i].exp_rsp_valid) begin
                check($sformatf("v%0d_rsp_addr", i), 32'(rsp_addr), 32'(vecs[i].exp_rsp.addr));
                check($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_rsp.data));
            end
            check($sformatf("v%0d_wrcount", i), 32'(wrcount), 32'(vecs[i].exp_wrcount));
            tick();
        end

        // Test 3: store is {0,1,2,0}; five back-to-back reads with no consumer, fifth refused.
        begin
            logic [1:0] ra [5];
            logic [3:0] rd [5];
            logic       rr [5];
            ra = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            rd = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd1};
            rr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 1'b1, ra[i], 1'b0);
                check($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'(rr[i]));
                tick();
            end
            drive(1'b0, 1'b0, 2'd0, 1'b0);
            for (int i = 0; i < 3; i++) tick();
            check("bp_full_req_ready", 32'(req_ready), 32'd0);
            expect_head("bp_hold", ra[0], rd[0]);
            drive(1'b0, 1'b0, 2'd0, 1'b1);
            for (int i = 0; i < 4; i++) begin
                expect_head($sformatf("bp_drain%0d", i), ra[i], rd[i]);
                tick();
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_empty%0d", i), 32'(rsp_valid), 32'd0);
                tick();
            end
        end

        // Test 4: sixteen writes wrap the tag; last stored tag is 15.
        do_reset("r1");
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0);
            check($sformatf("wrap_wc%0d", i), 32'(wrcount), 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check("wrap_wc_after16", 32'(wrcount), 32'd0);
        read_and_check("wrap_rd16", 2'd0, 4'd15);
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check("wrap_wc_after17", 32'(wrcount), 32'd1);
        read_and_check("wrap_rd17", 2'd0, 4'd0);

        // Test 5: store becomes {0,1,2,3}; pop coincides with the fourth read's FIFO push.
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'(i), 1'b0);
            tick();
        end
        check("pp_wc", 32'(wrcount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'(i), 1'b0);
            check($sformatf("pp_acc%0d", i), 32'(req_ready), 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        check("pp_pre_req_ready", 32'(req_ready), 32'd0);
        expect_head("pp_pop0", 2'd0, 4'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check("pp_post_req_ready", 32'(req_ready), 32'd1);
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            expect_head($sformatf("pp_drain%0d", i), 2'(i), 4'(i));
            tick();
        end
        check("pp_empty", 32'(rsp_valid), 32'd0);

        // Test 6: reset with one entry in the FIFO and two reads in the pipeline.
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'(i), 1'b0);
            tick();
        end
        check("mr_pre_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check("mr_req_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rsp_addr", 32'(rsp_addr), 32'd0);
        check("mr_rsp_data", 32'(rsp_data), 32'd0);
        check("mr_wrcount", 32'(wrcount), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mr_none%0d", i), 32'(rsp_valid), 32'd0);
        end
        read_and_check("mr_rd1", 2'd1, 4'd0);
        read_and_check("mr_rd3", 2'd3, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
